// File: rtl/pipo_rr_loader.sv
// pipo_rr_loader: round-robin load of NREQ valid/ready requesters into one held WIDTH-bit word; consumer side out_valid/out_ready/flush, plus out_src and a wrapping load_count
module pipo_rr_loader #(
  parameter int WIDTH = 4,
  parameter int NREQ = 4,
  parameter int CNTW = 8,
  localparam int SW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      parallel_out,
  output logic [SW-1:0]         out_src,
  output logic [CNTW-1:0]       load_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] ptr, winner, idx;
  logic found, can_load, grant;
  logic [WIDTH-1:0] words [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign words[i] = req_data[i*WIDTH +: WIDTH];
  end
  always_comb begin
    found = 1'b0;
    winner = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = SW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        winner = idx;
      end
    end
  end
  assign can_load = state == EMPTY || (out_ready && !flush);
  assign grant = can_load && found && !reset;
  assign req_ready = grant ? NREQ'(1) << winner : '0;
  assign out_valid = state == FULL;
  always_comb begin
    state_nxt = grant ? FULL : (state == FULL && (flush || out_ready)) ? EMPTY : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parallel_out <= '0;
      out_src <= '0;
      load_count <= '0;
      ptr <= '0;
    end else if (grant) begin
      parallel_out <= words[winner];
      out_src <= winner;
      load_count <= load_count + CNTW'(1);
      ptr <= SW'((int'(winner) + 1) % NREQ);
    end
  end
endmodule

// File: tb/tb_pipo_rr_loader.sv
// tb_pipo_rr_loader: directed self-checking bench for pipo_rr_loader (WIDTH=4, NREQ=4, CNTW=8)
module tb_pipo_rr_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_valid = '0;
  logic [15:0] req_data = '0;
  logic [3:0] req_ready;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [3:0] parallel_out;
  logic [1:0] out_src;
  logic [7:0] load_count;
  int tests = 0;
  int fails = 0;

  pipo_rr_loader #(.WIDTH(4), .NREQ(4), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .parallel_out(parallel_out), .out_src(out_src),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_d [5] = '{4'b0001, 4'b1010, 4'b1100, 4'b1111, 4'b0001};
    logic [1:0] exp_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_valid = 4'b1111;
    req_data = 16'b1111_1100_1010_0001;
    out_ready = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (parallel_out !== 4'b0) begin fails++; $display("FAIL reset_parallel_out got %b exp 0000", parallel_out); end
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    tests++; if (load_count !== 8'd0) begin fails++; $display("FAIL reset_load_count got %0d exp 0", load_count); end
    tick();
    tests++; if (req_ready !== 4'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_held got ready=%b valid=%b exp 0000/0", req_ready, out_valid); end
    reset = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL first_grant got %b exp 0001", req_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (out_valid !== 1'b1 || parallel_out !== exp_d[i] || out_src !== exp_s[i])
        begin fails++; $display("FAIL all_valid_seq[%0d] got v=%b d=%b s=%0d exp v=1 d=%b s=%0d", i, out_valid, parallel_out, out_src, exp_d[i], exp_s[i]); end
    end
    tests++; if (load_count !== 8'd5) begin fails++; $display("FAIL all_valid_count got %0d exp 5", load_count); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_data = 16'b0000_1001_0000_0000;
    out_ready = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1 || parallel_out !== 4'b1001 || out_src !== 2'd2)
      begin fails++; $display("FAIL single_load got v=%b d=%b s=%0d exp v=1 d=1001 s=2", out_valid, parallel_out, out_src); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL single_backpressure[%0d] got %b exp 0000", i, req_ready); end
      tick();
      tests++; if (out_valid !== 1'b1 || parallel_out !== 4'b1001) begin fails++; $display("FAIL single_hold[%0d] got v=%b d=%b exp v=1 d=1001", i, out_valid, parallel_out); end
    end
    req_valid = 4'b0000;
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_consume got %b exp 0", out_valid); end
    tests++; if (load_count !== 8'd1) begin fails++; $display("FAIL single_count got %0d exp 1", load_count); end
    tests++; if (parallel_out !== 4'b1001 || out_src !== 2'd2) begin fails++; $display("FAIL single_after_consume got d=%b s=%0d exp d=1001 s=2", parallel_out, out_src); end
  endtask

  task automatic test_fairness();
    logic [1:0] order [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    do_reset();
    req_valid = 4'b1011;
    req_data = 16'b1000_0100_0010_0001;
    out_ready = 1'b1;
    #1;
    for (int g = 0; g < 6; g++) begin
      tests++; if (req_ready !== 4'(1 << order[g])) begin fails++; $display("FAIL fair_grant[%0d] got %b exp %b", g, req_ready, 4'(1 << order[g])); end
      tick();
      tests++; if (out_src !== order[g] || parallel_out !== 4'(1 << order[g])) begin fails++; $display("FAIL fair_src[%0d] got s=%0d d=%b exp s=%0d", g, out_src, parallel_out, order[g]); end
      out_ready = 1'b0;
      #1;
      tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL fair_stall[%0d] got %b exp 0000", g, req_ready); end
      tick();
      tests++; if (out_src !== order[g] || out_valid !== 1'b1) begin fails++; $display("FAIL fair_hold[%0d] got s=%0d v=%b exp s=%0d v=1", g, out_src, out_valid, order[g]); end
      out_ready = 1'b1;
      #1;
    end
    tests++; if (load_count !== 8'd6) begin fails++; $display("FAIL fair_count got %0d exp 6", load_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 4'b0001;
    req_data = 16'b0000_0000_0000_1010;
    out_ready = 1'b0;
    tick();
    tests++; if (parallel_out !== 4'b1010 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_first got d=%b v=%b exp d=1010 v=1", parallel_out, out_valid); end
    req_valid = 4'b0010;
    req_data = 16'b0000_0000_0010_0000;
    out_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL b2b_grant got %b exp 0010", req_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || parallel_out !== 4'b0010 || out_src !== 2'd1)
      begin fails++; $display("FAIL b2b_reload got v=%b d=%b s=%0d exp v=1 d=0010 s=1", out_valid, parallel_out, out_src); end
  endtask

  task automatic test_flush();
    req_valid = 4'b0001;
    req_data = 16'b0000_0000_0000_0001;
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL flush_no_grant got %b exp 0000", req_ready); end
    tick();
    tests++; if (out_valid !== 1'b0 || parallel_out !== 4'b0010 || load_count !== 8'd2)
      begin fails++; $display("FAIL flush_discard got v=%b d=%b cnt=%0d exp v=0 d=0010 cnt=2", out_valid, parallel_out, load_count); end
    flush = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL flush_next_grant got %b exp 0001", req_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || parallel_out !== 4'b0001 || out_src !== 2'd0 || load_count !== 8'd3)
      begin fails++; $display("FAIL flush_reload got v=%b d=%b s=%0d cnt=%0d exp v=1 d=0001 s=0 cnt=3", out_valid, parallel_out, out_src, load_count); end
    req_valid = 4'b0000;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drain got %b exp 0", out_valid); end
    flush = 1'b1;
    req_valid = 4'b0010;
    req_data = 16'b0000_0000_0110_0000;
    tick();
    tests++; if (out_valid !== 1'b1 || parallel_out !== 4'b0110 || load_count !== 8'd4)
      begin fails++; $display("FAIL flush_empty_load got v=%b d=%b cnt=%0d exp v=1 d=0110 cnt=4", out_valid, parallel_out, load_count); end
    flush = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    tick();
    #3;
    reset = 1'b1;
    req_valid = 4'b1111;
    req_data = 16'b1111_1100_1010_0001;
    #1;
    tests++; if (out_valid !== 1'b0 || parallel_out !== 4'b0 || load_count !== 8'd0)
      begin fails++; $display("FAIL async_clear got v=%b d=%b cnt=%0d exp v=0 d=0000 cnt=0", out_valid, parallel_out, load_count); end
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL async_ready got %b exp 0000", req_ready); end
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL async_ptr got %b exp 0001", req_ready); end
    tick();
    tests++; if (out_src !== 2'd0 || parallel_out !== 4'b0001) begin fails++; $display("FAIL async_first got s=%0d d=%b exp s=0 d=0001", out_src, parallel_out); end
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0001;
    req_data = 16'h0005;
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    tests++; if (load_count !== 8'd255) begin fails++; $display("FAIL wrap_255 got %0d exp 255", load_count); end
    tick();
    tests++; if (load_count !== 8'd0 || out_valid !== 1'b1) begin fails++; $display("FAIL wrap_zero got cnt=%0d v=%b exp cnt=0 v=1", load_count, out_valid); end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
